// File: rtl/mem_access_stage.sv
// Memory-access pipeline stage: issues word loads/stores over a req/ack
// handshake. While an access is outstanding it holds the upstream stages
// frozen and registers a bubble toward write-back.
module mem_access_stage #(
  parameter int unsigned WORD_WIDTH     = 32,
  parameter int unsigned REG_FILE_DEPTH = 4,
  parameter int unsigned MEM_BASE       = 1024,
  parameter int unsigned MEM_ADDR_WIDTH = 16
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [WORD_WIDTH-1:0]     alu_res_in,
  input  logic [WORD_WIDTH-1:0]     val_Rm_in,
  input  logic [REG_FILE_DEPTH-1:0] dst_in,
  input  logic                      mem_read_in,
  input  logic                      mem_write_in,
  input  logic                      WB_en_in,
  output logic                      ready,
  output logic                      ext_req,
  output logic                      ext_we,
  output logic [MEM_ADDR_WIDTH-1:0] ext_addr,
  output logic [WORD_WIDTH-1:0]     ext_wdata,
  input  logic [WORD_WIDTH-1:0]     ext_rdata,
  input  logic                      ext_ack,
  output logic                      wb_en_out,
  output logic                      wb_mem_read_out,
  output logic [REG_FILE_DEPTH-1:0] wb_dst_out,
  output logic [WORD_WIDTH-1:0]     wb_alu_res_out,
  output logic [WORD_WIDTH-1:0]     wb_mem_data_out
);

  typedef enum logic [1:0] {StIdle, StAccess, StDone} state_e;

  state_e                      state_q, state_d;
  logic                        ext_req_q, ext_req_d;
  logic                        ext_we_q, ext_we_d;
  logic [MEM_ADDR_WIDTH-1:0]   ext_addr_q, ext_addr_d;
  logic [WORD_WIDTH-1:0]       ext_wdata_q, ext_wdata_d;
  logic [WORD_WIDTH-1:0]       rdata_buf_q, rdata_buf_d;
  logic                        wb_en_q, wb_en_d;
  logic                        wb_mem_read_q, wb_mem_read_d;
  logic [REG_FILE_DEPTH-1:0]   wb_dst_q, wb_dst_d;
  logic [WORD_WIDTH-1:0]       wb_alu_res_q, wb_alu_res_d;
  logic [WORD_WIDTH-1:0]       wb_mem_data_q, wb_mem_data_d;

  logic                        mem_op;
  logic [WORD_WIDTH-1:0]       byte_off;
  logic [MEM_ADDR_WIDTH-1:0]   word_addr;

  // Word address relative to the data-memory base; low byte bits dropped,
  // underflow simply wraps.
  always_comb begin
    mem_op    = mem_read_in | mem_write_in;
    byte_off  = alu_res_in - WORD_WIDTH'(MEM_BASE);
    word_addr = MEM_ADDR_WIDTH'(byte_off >> 2);
  end

  // Stall decision depends only on state and mem_op, never on ext_ack.
  always_comb begin
    ready = 1'b0;
    unique case (state_q)
      StIdle:   ready = ~mem_op;
      StAccess: ready = 1'b0;
      StDone:   ready = 1'b1;
      default:  ready = 1'b0;
    endcase
  end

  // Access FSM and external request registers.
  always_comb begin
    state_d     = state_q;
    ext_req_d   = ext_req_q;
    ext_we_d    = ext_we_q;
    ext_addr_d  = ext_addr_q;
    ext_wdata_d = ext_wdata_q;
    rdata_buf_d = rdata_buf_q;
    unique case (state_q)
      StIdle: begin
        if (mem_op) begin
          ext_req_d   = 1'b1;
          ext_we_d    = mem_write_in;  // write wins when both are set
          ext_addr_d  = word_addr;
          ext_wdata_d = val_Rm_in;
          state_d     = StAccess;
        end
      end
      StAccess: begin
        if (ext_ack) begin
          rdata_buf_d = ext_rdata;
          ext_req_d   = 1'b0;
          state_d     = StDone;
        end
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Write-back register: pass through when ready, bubble otherwise.
  always_comb begin
    wb_en_d       = 1'b0;
    wb_mem_read_d = 1'b0;
    wb_dst_d      = wb_dst_q;
    wb_alu_res_d  = wb_alu_res_q;
    wb_mem_data_d = wb_mem_data_q;
    if (ready) begin
      wb_en_d       = WB_en_in;
      wb_mem_read_d = mem_read_in & ~mem_write_in;
      wb_dst_d      = dst_in;
      wb_alu_res_d  = alu_res_in;
      if (state_q == StDone) begin
        wb_mem_data_d = rdata_buf_q;
      end
    end
  end

  // State update with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= StIdle;
      ext_req_q     <= 1'b0;
      ext_we_q      <= 1'b0;
      ext_addr_q    <= '0;
      ext_wdata_q   <= '0;
      rdata_buf_q   <= '0;
      wb_en_q       <= 1'b0;
      wb_mem_read_q <= 1'b0;
      wb_dst_q      <= '0;
      wb_alu_res_q  <= '0;
      wb_mem_data_q <= '0;
    end else begin
      state_q       <= state_d;
      ext_req_q     <= ext_req_d;
      ext_we_q      <= ext_we_d;
      ext_addr_q    <= ext_addr_d;
      ext_wdata_q   <= ext_wdata_d;
      rdata_buf_q   <= rdata_buf_d;
      wb_en_q       <= wb_en_d;
      wb_mem_read_q <= wb_mem_read_d;
      wb_dst_q      <= wb_dst_d;
      wb_alu_res_q  <= wb_alu_res_d;
      wb_mem_data_q <= wb_mem_data_d;
    end
  end

  // Output drives.
  always_comb begin
    ext_req         = ext_req_q;
    ext_we          = ext_we_q;
    ext_addr        = ext_addr_q;
    ext_wdata       = ext_wdata_q;
    wb_en_out       = wb_en_q;
    wb_mem_read_out = wb_mem_read_q;
    wb_dst_out      = wb_dst_q;
    wb_alu_res_out  = wb_alu_res_q;
    wb_mem_data_out = wb_mem_data_q;
  end

endmodule

// File: doc/mem_access_stage.md
# mem_access_stage

Memory-access stage of the 5-stage ARM pipeline; consumes the EXE/MEM pipeline register outputs and feeds the MEM/WB boundary. Performs loads and stores to an external word-wide data memory through a req/ack handshake. Freezes all upstream pipeline registers while an access is outstanding. Registers its results for the write-back stage, inserting a bubble on every stall cycle.

## Interface
Parameters:
- WORD_WIDTH, 32, datapath width
- REG_FILE_DEPTH, 4, destination-register index width
- MEM_BASE, 1024, byte address mapped to data-memory word 0
- MEM_ADDR_WIDTH, 16, external word-address width

Ports:
- clk  in  1  single clock; all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- alu_res_in  in  WORD_WIDTH  byte address for memory ops; result for ALU ops
- val_Rm_in  in  WORD_WIDTH  store data
- dst_in  in  REG_FILE_DEPTH  destination register
- mem_read_in, mem_write_in, WB_en_in  in  1 each  control from EXE/MEM register
- ready  out  1  0 = freeze IF/ID/EXE stages and EXE/MEM register
- ext_req  out  1  memory request, registered
- ext_we  out  1  1 = write, registered
- ext_addr  out  MEM_ADDR_WIDTH  word address, registered
- ext_wdata  out  WORD_WIDTH  write data, registered
- ext_rdata  in  WORD_WIDTH  read data, valid with ext_ack
- ext_ack  in  1  single-cycle completion pulse
- wb_en_out, wb_mem_read_out  out  1 each  registered to WB
- wb_dst_out  out  REG_FILE_DEPTH  registered
- wb_alu_res_out, wb_mem_data_out  out  WORD_WIDTH  registered

## Operation
- mem_op = mem_read_in | mem_write_in. If both are set, the write wins: the access is a store, and wb_mem_read_out is driven 0.
- Address: ext_addr = ((alu_res_in − MEM_BASE) >> 2) truncated to MEM_ADDR_WIDTH.
  - Address bits [1:0] are ignored.
  - Addresses below MEM_BASE wrap modulo 2^MEM_ADDR_WIDTH; no error is raised.
- FSM states: IDLE, ACCESS, DONE.
  - IDLE, mem_op=0: stay in IDLE; ready=1.
  - IDLE, mem_op=1: ready=0. At the edge, load ext_req=1, ext_we=mem_write_in, ext_addr and ext_wdata=val_Rm_in, then go to ACCESS.
  - ACCESS: ready=0. Hold ext_* stable until ext_ack=1. On ack: capture ext_rdata into rdata_buf, clear ext_req, go to DONE.
  - DONE: ready=1; go to IDLE at the next edge.
- ext_ack is ignored in IDLE and DONE.
- Upstream inputs are stable during ACCESS and DONE because they are frozen by ready=0.
- Output register, updated every edge:
  - ready=1: wb_en_out=WB_en_in, wb_dst_out=dst_in, wb_alu_res_out=alu_res_in, wb_mem_read_out=mem_read_in & ~mem_write_in, and wb_mem_data_out = (state==DONE) ? rdata_buf : previous value.
  - ready=0: bubble. wb_en_out=0 and wb_mem_read_out=0; the other wb_* outputs hold their values.
- ready is combinational from state and mem_op only; it has no path from ext_ack.

## Timing
- Reset: state=IDLE; ext_req, ext_we, ext_addr, ext_wdata, rdata_buf and all wb_* outputs = 0.
- ready reads 1 after reset unless mem_op is set, in which case it reads 0 (IDLE with mem_op).
- Non-memory instruction: 1 cycle, no stall; wb_* valid one edge after presentation.
- Memory instruction, ack arriving n cycles after ext_req rises (n≥0):
  - ready is low for n+2 cycles.
  - DONE lasts one cycle; wb_* are valid at the edge that leaves DONE.
  - Exactly one non-bubble WB entry is produced per instruction.
- ext_req is high for exactly n+1 cycles. The earliest legal ack is the first cycle ext_req is high.
- Back-to-back memory ops: DONE → IDLE → the next instruction starts its own access; there is no overlap.
- rst during ACCESS: ext_req drops on that edge; a later stray ack is ignored; no WB entry is produced.

## Test plan
- Reset with mem_op=0: all outputs 0, ready=1. After 1 edge with ALU op (alu_res_in=0x55, dst=3, WB_en=1): wb_alu_res_out=0x55, wb_dst_out=3, wb_en_out=1.
- Store with alu_res_in=1032, val_Rm_in=0xDEADBEEF, ack after 2 cycles:
  - ext_addr=2, ext_we=1, ext_wdata=0xDEADBEEF, ext_req high 3 cycles.
  - ready low 4 cycles; bubbles emitted during the stall; wb_en_out=0 after completion.
- Load with alu_res_in=1024, ack at n=0 with rdata=0x12345678: ext_addr=0, ready low 2 cycles, then wb_mem_data_out=0x12345678 and wb_mem_read_out=1.
- mem_read_in=mem_write_in=1: ext_we=1, wb_mem_read_out=0.
- rst asserted in ACCESS, then ack pulsed 2 cycles later: ext_req=0 from the reset edge, state stays IDLE, no non-bubble WB output.
- Two consecutive loads at 1028 and 1036 with distinct rdata: two separate accesses to addr 1 then 3; each wb_mem_data_out matches its own rdata.
